branch_stack_ctrl: RTL

Loop-branch controller for the BeeF core, replacing linear bracket search on backward branches with a parametrised hardware loop stack. On `CBF` with a non-zero working cell the CBF address is pushed; on `CBB` with a non-zero cell the core jumps directly to the instruction after the stacked CBF, with no backward search. Forward skips (CBF with zero cell) still use a nesting-counter search, with a configurable counter width. Sits beside the fetch unit: consumes decoded instruction, PC and working cell; drives redirect and search-mode signals back to fetch/execute.

---
 rtl/branch_stack_ctrl_if.sv | 27 ++
 rtl/branch_stack_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/branch_stack_ctrl_if.sv
// rtl/branch_stack_ctrl_if.sv - core-side bundle for the loop-branch stack controller
interface branch_stack_ctrl_if #(
  parameter int PCWidth = 16,
  parameter int Depth   = 8
);
  logic                       valid;
  logic [8:0]                 instruction;
  logic [PCWidth-1:0]         pc;
  logic [7:0]                 working;
  logic                       clear;
  logic                       searching;
  logic                       jump;
  logic [PCWidth-1:0]         jump_target;
  logic [$clog2(Depth+1)-1:0] stack_depth;
  logic                       overflow;
  logic                       underflow;

  modport master (
    output valid, instruction, pc, working, clear,
    input  searching, jump, jump_target, stack_depth, overflow, underflow
  );

  modport slave (
    input  valid, instruction, pc, working, clear,
    output searching, jump, jump_target, stack_depth, overflow, underflow
  );
endinterface

// File: rtl/branch_stack_ctrl.sv
// rtl/branch_stack_ctrl.sv - hardware loop stack for CBF/CBB with forward nesting search
module branch_stack_ctrl #(
  parameter int         PCWidth   = 16,
  parameter int         Depth     = 8,
  parameter int         NestWidth = 8,
  parameter logic [8:0] OpCbf     = 9'h05b,
  parameter logic [8:0] OpCbb     = 9'h05d
) (
  input logic               clk,
  input logic               rst_n,
  branch_stack_ctrl_if.slave bus
);
  localparam int DW = $clog2(Depth + 1);
  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;

  typedef enum logic {EXEC, SEARCH} state_t;

  state_t               state, state_n;
  logic [NestWidth-1:0] nest, nest_n;
  logic [DW-1:0]        depth, depth_n;
  logic                 jump_q, jump_n;
  logic [PCWidth-1:0]   target_q, target_n;
  logic                 ovf_q, ovf_n;
  logic                 unf_q, unf_n;
  logic                 push;
  logic [PCWidth-1:0]   stack_mem [Depth];

  logic               is_cbf, is_cbb, cell_zero, full, empty;
  logic [AW-1:0]      wr_idx, top_idx;
  logic [PCWidth-1:0] top;

  assign is_cbf    = (bus.instruction == OpCbf);
  assign is_cbb    = (bus.instruction == OpCbb);
  assign cell_zero = (bus.working == 8'd0);
  assign full      = (depth == DW'(Depth));
  assign empty     = (depth == '0);
  assign wr_idx    = depth[AW-1:0];
  assign top_idx   = AW'(depth - DW'(1));
  // Top of stack comes straight off the array so the target registers with the CBB itself.
  assign top       = stack_mem[top_idx];

  always_comb begin
    state_n  = state;
    nest_n   = nest;
    depth_n  = depth;
    jump_n   = 1'b0;
    target_n = target_q;
    ovf_n    = ovf_q;
    unf_n    = unf_q;
    push     = 1'b0;
    if (bus.clear) begin
      state_n = EXEC;
      nest_n  = '0;
      depth_n = '0;
      ovf_n   = 1'b0;
      unf_n   = 1'b0;
    end else if (bus.valid) begin
      unique case (state)
        EXEC: begin
          if (is_cbf) begin
            if (cell_zero) begin
              nest_n  = NestWidth'(1);
              state_n = SEARCH;
            end else if (full) begin
              ovf_n = 1'b1;
            end else begin
              push    = 1'b1;
              depth_n = depth + DW'(1);
            end
          end else if (is_cbb) begin
            if (empty) begin
              unf_n = 1'b1;
            end else if (!cell_zero) begin
              jump_n   = 1'b1;
              target_n = top + PCWidth'(1);
            end else begin
              depth_n = depth - DW'(1);
            end
          end
        end
        SEARCH: begin
          if (is_cbf) begin
            if (nest == '1) ovf_n = 1'b1;
            else            nest_n = nest + NestWidth'(1);
          end else if (is_cbb) begin
            nest_n = nest - NestWidth'(1);
            if (nest == NestWidth'(1)) state_n = EXEC;
          end
        end
        default: state_n = EXEC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EXEC;
      nest     <= '0;
      depth    <= '0;
      jump_q   <= 1'b0;
      target_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state    <= state_n;
      nest     <= nest_n;
      depth    <= depth_n;
      jump_q   <= jump_n;
      target_q <= target_n;
      ovf_q    <= ovf_n;
      unf_q    <= unf_n;
    end
  end

  // Entries above depth are dead, so the array itself needs no reset.
  always_ff @(posedge clk) begin
    if (push) stack_mem[wr_idx] <= bus.pc;
  end

  assign bus.searching   = (state == SEARCH);
  assign bus.jump        = jump_q;
  assign bus.jump_target = target_q;
  assign bus.stack_depth = depth;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;
endmodule
